sertx_box: RTL and testbench
============================

# sertx_box

Parallel-in/serial-out transmit cell with invertible pins, modelling a shift-register primitive whose inverting stages are absorbed into the cell as pin-polarity parameters rather than kept as separate `$_NOT_` cells. It is the driving end of an invertible-pin path: `INV_DO` absorbs an inverter on the serial output, and `INV_LOAD` absorbs an inverter on the load strobe. It serves as a simulation model and as a synthesis test target for the inverter-integration flow; pin polarity is fixed per instance by parameter.

## Interface
- `WIDTH`, 8: data bits per frame; legal range is 2 or more.
- `IDLE_LEVEL`, 1'b1: un-inverted line level when no frame is active.
- `INV_DO`, 1'b0: invertible-pin parameter for `dout`; when 1, the driven level is inverted.
- `INV_LOAD`, 1'b0: invertible-pin parameter for `load`; when 1, the strobe is active-low.
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `din`, input, WIDTH: parallel frame data, sampled on acceptance.
- `load`, input, 1: frame strobe, carrying the `invertible_pin="INV_LOAD"` attribute. Effective strobe `ld = load ^ INV_LOAD`.
- `ready`, output, 1: the cell can accept `ld` at the next edge.
- `dout`, output, 1: serial line, carrying the `invertible_pin="INV_DO"` attribute. `dout = q ^ INV_DO`, where `q` is the internal registered line value.
- `busy`, output, 1: a data or parity bit is on the line this cycle.
- `done`, output, 1: one-cycle pulse, high during the final bit of a frame.

## Operation
- States: IDLE and SHIFT. Registers: shift register `sr[WIDTH-1:0]`, bit counter `cnt` (width `$clog2(WIDTH+1)`), line register `q`.
- Bit order: MSB first, `din[WIDTH-1]` first.
- `ready = (state==IDLE) | last`. `last` is high in SHIFT during the final bit of the frame: data bit WIDTH-1, or the parity bit when parity is compiled in.
- Acceptance is an edge where `ready & ld`. On acceptance:
  - `q <= din[WIDTH-1]`;
  - `sr <= din << 1`;
  - `cnt <= 1`;
  - state becomes SHIFT.
- SHIFT, not `last`: `q <= sr[WIDTH-1]`, `sr <= sr << 1`, `cnt <= cnt+1`.
- SHIFT, `last`, no acceptance: state becomes IDLE and `q <= IDLE_LEVEL`.
- SHIFT, `last`, with acceptance: the next frame starts at that edge, leaving no idle gap between frames.
- `busy = (state==SHIFT)`. `done = last`.
- `ld` is ignored whenever `ready`=0. `din` is don't-care except at acceptance.
- `load` and `din` carry no X-filtering; the bench must drive them to known values.

## Timing
- Reset values: state IDLE, `sr`=0, `cnt`=0, `q`=IDLE_LEVEL. Outputs after reset:
  - `dout` = IDLE_LEVEL^INV_DO;
  - `ready`=1;
  - `busy`=0;
  - `done`=0.
- Latency: bit k (k=0 is the MSB) is on `dout` during cycle k+1 after the acceptance edge.
- Without parity, a frame occupies cycles 1..WIDTH; with parity, cycles 1..WIDTH+1.
- `dout`, `busy`, `state` and `q` are registered, so `dout` has no combinational path from any input.
- `ready` and `done` are decoded from registered state only.
- Reset mid-frame: at the reset edge, the frame is aborted and `dout` returns to the idle level. `done` is not pulsed for the aborted frame. A `ld` in the same cycle as `rst` is ignored.
- Back-to-back frames: continuous line with no idle bit between frames. `done` pulses once per frame.

## Configuration
- `SERTX_PARITY_EN` defined: an extra bit is sent after data bit WIDTH-1, with value `^din` (even parity) computed on the accepted frame and held in a parity register. `last` moves to this bit.
- `SERTX_PARITY_EN` undefined: no parity register, and a frame is exactly WIDTH bits.

## Test plan
- Reset, WIDTH=8, defaults: `dout`=1, `ready`=1, `busy`=0, `done`=0. Holding `rst`=1 for 3 cycles changes nothing.
- `din`=8'hA5 with a one-cycle `load`=1:
  - `dout` = 1,0,1,0,0,1,0,1 in cycles 1..8;
  - `busy` high in cycles 1..8;
  - `done` high only in cycle 8;
  - `dout`=1 in cycle 9.
- INV_DO=1, INV_LOAD=1, `load` held at 1: idle `dout`=0 and no frame starts. Driving `load`=0 for one cycle with `din`=8'h3C gives `dout` = 1,1,0,0,0,0,1,1.
- Back-to-back: frames 8'hFF then 8'h00, with `load` asserted in the cycle where `done`=1 for the first frame. Required response:
  - `dout` is 8 ones followed by 8 zeros with no gap;
  - `done` pulses in cycles 8 and 16;
  - a `load` pulse in cycle 4 is ignored.
- `rst` asserted in cycle 3 of frame 8'h81: `dout`=1 and `busy`=0 from the next cycle, with no `done` pulse.
- Build with `SERTX_PARITY_EN`, `din`=8'h07: 9-bit frame with parity bit 1, `done` in cycle 9.

Source files
------------

// File: rtl/sertx_box_if.sv
// Frame-side bus of the sertx_box transmit cell: parallel load in, serial line and status out.
interface sertx_box_if #(
   parameter int unsigned WIDTH = 8
);
   logic [WIDTH-1:0] din;
   (* invertible_pin = "INV_LOAD" *) logic load;
   logic ready;
   (* invertible_pin = "INV_DO" *) logic dout;
   logic busy;
   logic done;

   modport master (
      output din,
      output load,
      input  ready,
      input  dout,
      input  busy,
      input  done
   );

   modport slave (
      input  din,
      input  load,
      output ready,
      output dout,
      output busy,
      output done
   );
endinterface

// File: rtl/sertx_box.sv
// Parallel-in/serial-out transmit cell, MSB first, with pin polarity absorbed as INV_DO/INV_LOAD.
// Optional even-parity bit after the data bits when SERTX_PARITY_EN is defined.
module sertx_box #(
   parameter int unsigned WIDTH      = 8,
   parameter logic        IDLE_LEVEL = 1'b1,
   parameter logic        INV_DO     = 1'b0,
   parameter logic        INV_LOAD   = 1'b0
) (
   input logic        clk,
   input logic        rst,
   sertx_box_if.slave bus
);

`ifdef SERTX_PARITY_EN
   localparam int unsigned CNT_W    = $clog2(WIDTH + 2);
   localparam int unsigned LAST_CNT = WIDTH + 1;
`else
   localparam int unsigned CNT_W    = $clog2(WIDTH + 1);
   localparam int unsigned LAST_CNT = WIDTH;
`endif

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_SHIFT = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             q_q, q_d;
`ifdef SERTX_PARITY_EN
   logic             par_q, par_d;
`endif

   logic ld_c;
   logic last_c;
   logic ready_c;
   logic accept_c;

   // cnt holds the 1-based index of the bit currently on the line
   assign ld_c     = bus.load ^ INV_LOAD;
   assign last_c   = (state_q == S_SHIFT) && (cnt_q == CNT_W'(LAST_CNT));
   assign ready_c  = (state_q == S_IDLE) || last_c;
   assign accept_c = ready_c && ld_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         sr_q    <= '0;
         cnt_q   <= '0;
         q_q     <= IDLE_LEVEL;
`ifdef SERTX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
`ifdef SERTX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   // Acceptance has priority so a new frame can start on the final bit of the previous one
   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      q_d     = q_q;
`ifdef SERTX_PARITY_EN
      par_d   = par_q;
`endif
      if (accept_c) begin
         state_d = S_SHIFT;
         q_d     = bus.din[WIDTH-1];
         sr_d    = bus.din << 1;
         cnt_d   = CNT_W'(1);
`ifdef SERTX_PARITY_EN
         par_d   = ^bus.din;
`endif
      end else if (state_q == S_SHIFT) begin
         if (last_c) begin
            state_d = S_IDLE;
            q_d     = IDLE_LEVEL;
         end else begin
            sr_d  = sr_q << 1;
            cnt_d = cnt_q + CNT_W'(1);
`ifdef SERTX_PARITY_EN
            q_d   = (cnt_q == CNT_W'(WIDTH)) ? par_q : sr_q[WIDTH-1];
`else
            q_d   = sr_q[WIDTH-1];
`endif
         end
      end
   end

   assign bus.dout  = q_q ^ INV_DO;
   assign bus.ready = ready_c;
   assign bus.busy  = (state_q == S_SHIFT);
   assign bus.done  = last_c;

endmodule

// File: tb/tb_sertx_box.sv
// Bench for sertx_box: a plain and an inverted-pin instance driven by the same effective strobe,
// both checked every cycle against a queue-of-line-bits reference model.
module tb_sertx_box;

   localparam int unsigned W = 8;
`ifdef SERTX_PARITY_EN
   localparam int unsigned PAR = 1;
`else
   localparam int unsigned PAR = 0;
`endif

   logic clk;
   logic rst;

   sertx_box_if #(.WIDTH(W)) ifa ();
   sertx_box_if #(.WIDTH(W)) ifb ();

   sertx_box #(.WIDTH(W)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa.slave)
   );

   sertx_box #(.WIDTH(W), .INV_DO(1'b1), .INV_LOAD(1'b1)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // front of the queue is the bit on the line this cycle; empty means idle
   bit mq[$];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_update(input logic r, input logic l, input logic [W-1:0] d);
      bit rdy;
      rdy = (mq.size() <= 1);
      if (r) begin
         mq.delete();
      end else begin
         if (mq.size() > 0) mq.delete(0);
         if (rdy && l) begin
            for (int i = W - 1; i >= 0; i--) mq.push_back(d[i]);
            if (PAR != 0) mq.push_back(^d);
         end
      end
   endtask

   task automatic check_all();
      logic ed, edn, er, eb, edo;
      ed  = (mq.size() > 0) ? mq[0] : 1'b1;
      edn = ~ed;
      er  = (mq.size() <= 1);
      eb  = (mq.size() > 0);
      edo = (mq.size() == 1);
      check_eq("dout",    32'(ifa.dout),  32'(ed));
      check_eq("ready",   32'(ifa.ready), 32'(er));
      check_eq("busy",    32'(ifa.busy),  32'(eb));
      check_eq("done",    32'(ifa.done),  32'(edo));
      check_eq("dout_inv",  32'(ifb.dout),  32'(edn));
      check_eq("ready_inv", 32'(ifb.ready), 32'(er));
      check_eq("done_inv",  32'(ifb.done),  32'(edo));
   endtask

   // l is the effective strobe; the inverted instance sees its complement on load
   task automatic cycle(input logic r, input logic l, input logic [W-1:0] d);
      rst      = r;
      ifa.load = l;
      ifb.load = ~l;
      ifa.din  = d;
      ifb.din  = d;
      @(posedge clk);
      model_update(r, l, d);
      @(negedge clk);
      check_all();
   endtask

   initial begin
      logic [W-1:0] cap;
      rst      = 1'b1;
      ifa.load = 1'b0;
      ifb.load = 1'b1;
      ifa.din  = '0;
      ifb.din  = '0;
      @(negedge clk);

      // reset held for several cycles
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, W'(8'h00));
      cycle(1'b0, 1'b0, W'(8'h00));

      // single frame 8'hA5, line captured and compared to the frame value
      cap = '0;
      cycle(1'b0, 1'b1, W'(8'hA5));
      for (int i = 0; i < W; i++) begin
         cap = {cap[W-2:0], ifa.dout};
         if (i < W - 1) cycle(1'b0, 1'b0, W'($urandom));
      end
      check_eq("a5_frame", 32'(cap), 32'(8'hA5));
      for (int i = 0; i < 2 + PAR; i++) cycle(1'b0, 1'b0, W'($urandom));

      // 8'h3C through both instances
      cycle(1'b0, 1'b1, W'(8'h3C));
      for (int i = 0; i < W + PAR + 1; i++) cycle(1'b0, 1'b0, W'($urandom));

      // back-to-back FF then 00; strobe in cycle 4 must be ignored
      cycle(1'b0, 1'b1, W'(8'hFF));
      for (int c = 1; c < W + PAR; c++) cycle(1'b0, (c == 4), W'($urandom));
      cycle(1'b0, 1'b1, W'(8'h00));
      for (int i = 0; i < W + PAR + 1; i++) cycle(1'b0, 1'b0, W'($urandom));

      // reset in cycle 3 of frame 8'h81, with a strobe in the same cycle
      cycle(1'b0, 1'b1, W'(8'h81));
      cycle(1'b0, 1'b0, W'(8'h00));
      cycle(1'b0, 1'b0, W'(8'h00));
      cycle(1'b1, 1'b1, W'(8'h55));
      for (int i = 0; i < W + PAR; i++) cycle(1'b0, 1'b0, W'(8'h00));

      // randomized traffic with occasional resets
      for (int i = 0; i < 1500; i++) begin
         cycle(($urandom_range(63) == 0), ($urandom_range(2) == 0), W'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
